// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: state encoding, product
// codes, cost table, coin values and the credit ceiling.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_HELLO,
        ST_PRICE_LIST,
        ST_PAY,
        ST_DISPENSE,
        ST_CHANGE
    } state_t;

    localparam logic [3:0] PROD_NONE = 4'd0;
    localparam logic [3:0] PROD_1    = 4'd1;
    localparam logic [3:0] PROD_2    = 4'd2;
    localparam logic [3:0] PROD_3    = 4'd3;
    localparam logic [3:0] PROD_4    = 4'd4;

    localparam logic [7:0] COST_1 = 8'd2;
    localparam logic [7:0] COST_2 = 8'd4;
    localparam logic [7:0] COST_3 = 8'd6;
    localparam logic [7:0] COST_4 = 8'd10;

    localparam logic [7:0] COIN_HALF_VAL = 8'd1;
    localparam logic [7:0] COIN_ONE_VAL  = 8'd2;
    localparam logic [7:0] COIN_FIVE_VAL = 8'd10;

    localparam logic [8:0] MONEY_MAX = 9'd200;

    // Cost in money units of a latched product code; unknown codes cost nothing.
    function automatic logic [7:0] productCost(input logic [3:0] code);
        logic [7:0] cost;
        cost = 8'd0;
        case (code)
            PROD_1:  cost = COST_1;
            PROD_2:  cost = COST_2;
            PROD_3:  cost = COST_3;
            PROD_4:  cost = COST_4;
            default: cost = 8'd0;
        endcase
        return cost;
    endfunction

    // A selection code names a real product only in the range 1..4.
    function automatic logic isValidCode(input logic [2:0] code);
        return ({1'b0, code} >= PROD_1) && ({1'b0, code} <= PROD_4);
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Up-counter shared by the idle timeout and the dispense hold time.
// Counts from zero after a clear and raises done once it reaches the load
// value, where it parks until cleared again.
module vend_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_load,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    assign o_done = (r_count == i_load);

    // Restart on reset or clear, otherwise count up and hold at the load value.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (!o_done) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/vending_controller.sv
// Vending machine controller: greets, shows prices, collects coins, sells
// one product per confirm, holds the dispense line, then returns change.
// Every output comes straight from a register.
module vending_controller
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 30000000,
    parameter int DISPENSE_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_half,
    input  logic       coin_one,
    input  logic       coin_five,
    input  logic       show,
    input  logic       sel_valid,
    input  logic [2:0] sel_code,
    input  logic       confirm,
    input  logic       cancel,
    output logic [3:0] price,
    output logic [7:0] money,
    output logic       display_hello,
    output logic       display_price,
    output logic       dispense,
    output logic       change_valid,
    output logic [7:0] change_out,
    output logic       coin_reject
);

    localparam logic [31:0] IDLE_LOAD = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] DISP_LOAD = 32'(DISPENSE_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_money;
    logic [3:0]  r_price;
    logic        r_dispHello;
    logic        r_dispPrice;
    logic        r_dispense;
    logic        r_changeValid;
    logic [7:0]  r_changeOut;
    logic        r_coinReject;

    state_t      w_nextState;
    logic [7:0]  w_nextMoney;
    logic [3:0]  w_nextPrice;
    logic        w_nextReject;
    logic        w_nextChangeValid;
    logic [7:0]  w_nextChangeOut;
    logic        w_timerClear;
    logic        w_timerDone;
    logic [31:0] w_timerLoad;

    logic [7:0]  w_coinSum;
    logic        w_anyCoin;
    logic [8:0]  w_moneySum;
    logic        w_coinOk;
    logic [7:0]  w_payMoney;
    logic [7:0]  w_cost;
    logic        w_selOk;
    logic [3:0]  w_selCode;

    assign w_coinSum  = (coin_half ? COIN_HALF_VAL : 8'd0)
                      + (coin_one  ? COIN_ONE_VAL  : 8'd0)
                      + (coin_five ? COIN_FIVE_VAL : 8'd0);
    assign w_anyCoin  = coin_half | coin_one | coin_five;
    assign w_moneySum = {1'b0, r_money} + {1'b0, w_coinSum};
    assign w_coinOk   = w_anyCoin && (w_moneySum <= MONEY_MAX);
    assign w_payMoney = w_coinOk ? w_moneySum[7:0] : r_money;
    assign w_cost     = productCost(r_price);
    assign w_selOk    = sel_valid && isValidCode(sel_code);
    assign w_selCode  = {1'b0, sel_code};

    assign w_timerLoad = (r_state == ST_DISPENSE) ? DISP_LOAD : IDLE_LOAD;

    vend_timer #(
        .WIDTH (32)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_timerClear),
        .i_load  (w_timerLoad),
        .o_done  (w_timerDone)
    );

    // Next state and next register values; cancel beats confirm beats select,
    // and an accepted coin is credited before the cost is taken away.
    always_comb begin
        w_nextState       = r_state;
        w_nextMoney       = r_money;
        w_nextPrice       = r_price;
        w_nextReject      = 1'b0;
        w_nextChangeValid = 1'b0;
        w_nextChangeOut   = 8'd0;
        w_timerClear      = 1'b0;
        case (r_state)
            ST_HELLO: begin
                w_nextReject = w_anyCoin;
                w_timerClear = 1'b1;
                if (w_selOk) begin
                    w_nextState = ST_PAY;
                    w_nextPrice = w_selCode;
                end else if (show) begin
                    w_nextState = ST_PRICE_LIST;
                end
            end
            ST_PRICE_LIST: begin
                w_nextReject = w_anyCoin;
                if (w_selOk) begin
                    w_nextState  = ST_PAY;
                    w_nextPrice  = w_selCode;
                    w_timerClear = 1'b1;
                end else if (w_timerDone) begin
                    w_nextState  = ST_HELLO;
                    w_timerClear = 1'b1;
                end
            end
            ST_PAY: begin
                w_nextReject = w_anyCoin && !w_coinOk;
                w_nextMoney  = w_payMoney;
                if (cancel) begin
                    w_nextState       = ST_CHANGE;
                    w_nextChangeValid = 1'b1;
                    w_nextChangeOut   = w_payMoney;
                    w_timerClear      = 1'b1;
                end else if (confirm && (w_payMoney >= w_cost)) begin
                    w_nextState  = ST_DISPENSE;
                    w_nextMoney  = w_payMoney - w_cost;
                    w_timerClear = 1'b1;
                end else if (w_selOk) begin
                    w_nextPrice  = w_selCode;
                    w_timerClear = 1'b1;
                end else if (w_coinOk) begin
                    w_timerClear = 1'b1;
                end else if (w_timerDone) begin
                    w_nextState       = ST_CHANGE;
                    w_nextChangeValid = 1'b1;
                    w_nextChangeOut   = r_money;
                    w_timerClear      = 1'b1;
                end
            end
            ST_DISPENSE: begin
                w_nextReject = w_anyCoin;
                if (w_timerDone) begin
                    w_nextState       = ST_CHANGE;
                    w_nextChangeValid = 1'b1;
                    w_nextChangeOut   = r_money;
                    w_timerClear      = 1'b1;
                end
            end
            ST_CHANGE: begin
                w_nextReject = w_anyCoin;
                w_nextState  = ST_HELLO;
                w_nextMoney  = 8'd0;
                w_nextPrice  = PROD_NONE;
                w_timerClear = 1'b1;
            end
            default: begin
                w_nextState  = ST_HELLO;
                w_nextMoney  = 8'd0;
                w_nextPrice  = PROD_NONE;
                w_timerClear = 1'b1;
            end
        endcase
    end

    // State and output registers; display and dispense flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_HELLO;
            r_money       <= 8'd0;
            r_price       <= PROD_NONE;
            r_dispHello   <= 1'b1;
            r_dispPrice   <= 1'b0;
            r_dispense    <= 1'b0;
            r_changeValid <= 1'b0;
            r_changeOut   <= 8'd0;
            r_coinReject  <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_money       <= w_nextMoney;
            r_price       <= w_nextPrice;
            r_dispHello   <= (w_nextState == ST_HELLO);
            r_dispPrice   <= (w_nextState == ST_PRICE_LIST);
            r_dispense    <= (w_nextState == ST_DISPENSE);
            r_changeValid <= w_nextChangeValid;
            r_changeOut   <= w_nextChangeOut;
            r_coinReject  <= w_nextReject;
        end
    end

    assign price         = r_price;
    assign money         = r_money;
    assign display_hello = r_dispHello;
    assign display_price = r_dispPrice;
    assign dispense      = r_dispense;
    assign change_valid  = r_changeValid;
    assign change_out    = r_changeOut;
    assign coin_reject   = r_coinReject;

endmodule

// File: doc/vending_controller.md
VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 30000000: idle cycles before abandoning PRICE_LIST or PAY.
REQ-002 SHALL have parameter DISPENSE_CYCLES, default 5000000: cycles dispense is held high.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports coin_half, coin_one, coin_five, input, 1 bit each: debounced single-cycle coin pulses worth 1, 2 and 10 money units (1 unit = 0.5 yuan).
REQ-006 SHALL have port show, input, 1 bit: single-cycle request to show the price list.
REQ-007 SHALL have ports sel_valid (input, 1 bit) and sel_code (input, 3 bits): product selection; codes 1..4 valid, all others ignored.
REQ-008 SHALL have ports confirm and cancel, input, 1 bit each: single-cycle buyer buttons.
REQ-009 SHALL have port price, output, 4 bits: latched product code 0..4 driving the display stage.
REQ-010 SHALL have port money, output, 8 bits: current credit in units.
REQ-011 SHALL have ports display_hello and display_price, output, 1 bit each: display mode flags.
REQ-012 SHALL have port dispense, output, 1 bit: held high while the product is released.
REQ-013 SHALL have ports change_valid (output, 1 bit) and change_out (output, 8 bits): change returned, qualified by a 1-cycle change_valid.
REQ-014 SHALL have port coin_reject, output, 1 bit: 1-cycle pulse when the coins inserted that cycle are refused.

Function
REQ-015 SHALL implement states HELLO, PRICE_LIST, PAY, DISPENSE, CHANGE; all outputs SHALL be registered.
REQ-016 SHALL map product code to cost as 1->2, 2->4, 3->6, 4->10 units.
REQ-017 SHALL form the coin sum from all coin inputs asserted in the same cycle.
REQ-018 In PAY, SHALL add the coin sum to money unless money+sum > 200; an over-limit sum SHALL be rejected whole with coin_reject.
REQ-019 In HELLO, PRICE_LIST, DISPENSE and CHANGE, SHALL reject any coin with coin_reject and leave money unchanged.
REQ-020 HELLO: display_hello=1, display_price=0; show->PRICE_LIST; valid sel->PAY with price latched.
REQ-021 PRICE_LIST: display_price=1, display_hello=0; valid sel->PAY with price latched; timeout->HELLO.
REQ-022 PAY: both display flags 0; valid sel SHALL replace price and keep money.
REQ-023 PAY: confirm with money >= cost SHALL go to DISPENSE and subtract cost in that same edge; confirm with money < cost SHALL be ignored.
REQ-024 PAY: cancel or timeout SHALL go to CHANGE; cancel SHALL take priority over confirm, and confirm over sel, in the same cycle.
REQ-025 A coin accepted in the same cycle as a successful confirm SHALL be added before cost is subtracted.
REQ-026 DISPENSE: dispense=1 for exactly DISPENSE_CYCLES cycles, then CHANGE; all inputs ignored except rst.
REQ-027 CHANGE: single cycle; change_valid=1, change_out=money (0 allowed); next edge money=0, price=0, state HELLO.
REQ-028 The idle timer SHALL clear on state entry and on any accepted event. Timeout SHALL fire when the timer reaches TIMEOUT_CYCLES-1.

Reset
REQ-029 On rst, the next edge SHALL set state HELLO, money 0, price 0, display_hello 1, display_price 0, dispense 0, change_valid 0, change_out 0, coin_reject 0, and timers 0.
REQ-030 rst mid-DISPENSE or mid-PAY SHALL discard credit without a change_valid pulse; rst SHALL override all inputs.

Structure
REQ-031 Package vend_pkg SHALL hold the state encoding, product codes, the cost table, coin values, and MONEY_MAX=200.
REQ-032 A single sub-module vend_timer SHALL be used for both the idle and dispense counts, with a clear input, a load value, and a done output.

Verification (bench uses TIMEOUT_CYCLES=20, DISPENSE_CYCLES=4)
REQ-033 rst, then sel code 2, coin_five, confirm -> money 10->6, dispense high 4 cycles, change_valid with change_out=6, then HELLO with display_hello=1.
REQ-034 sel code 4, coin_one, confirm -> ignored, state stays PAY, money=2; cancel -> change_out=2.
REQ-035 In PAY with money 195, coin_five -> coin_reject pulse, money stays 195; coin_half+coin_one in the same cycle -> money 198.
REQ-036 show, then 20 idle cycles -> display_price falls, display_hello=1; coin in HELLO -> coin_reject, money=0.
REQ-037 PAY with money 4, no input for 20 cycles -> change_valid with change_out=4, then money=0, price=0.
REQ-038 rst asserted in the 2nd DISPENSE cycle -> next edge all outputs at their reset values, with no change_valid pulse.
